alu_sequencer: RTL and testbench

Handshaked front end for the team's combinational arithmetic unit (add/sub/and/or).
- Accepts one operation command at a time and drives the unit's `term0`/`term1`/`sel` inputs from registers.
- Captures the unit's `result` and returns it on a valid/ready response channel.
- Keeps an internal accumulator so commands can chain on the previous result.
- Sits between a controller or bus slave and one arithmetic unit instance.

---
 rtl/alu_sequencer.sv | 107 ++++++++++
 tb/tb_alu_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Handshaked front end that registers operands for an external add/sub/and/or unit
// and returns its result; define ALU_SEQ_CHECK_EN to compile in a sticky result checker.
module alu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_acc,
    output logic [WIDTH-1:0] alu_term0,
    output logic [WIDTH-1:0] alu_term1,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] acc;
    logic             accept;
    logic             rsp_fire;

    assign cmd_ready = (state == IDLE) & ~rst;
    assign accept    = cmd_valid & cmd_ready;
    assign rsp_fire  = rsp_valid & rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: default first so every path assigns state_next and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_term0 <= '0;
            alu_term1 <= '0;
            alu_sel   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            acc       <= '0;
        end else begin
            if (accept) begin
                alu_sel   <= cmd_op;
                alu_term1 <= cmd_b;
                alu_term0 <= cmd_acc ? acc : cmd_a;
            end
            if (state == EXEC) begin
                rsp_data  <= alu_result;
                rsp_zero  <= (alu_result == '0);
                acc       <= alu_result;
                rsp_valid <= 1'b1;
            end else if (rsp_fire) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_CHECK_EN
    logic [WIDTH-1:0] expected;

    // Reference model of the attached unit, evaluated on the registered operands.
    always_comb begin
        expected = '0;
        unique case (alu_sel)
            2'd0: expected = alu_term0 + alu_term1;
            2'd1: expected = alu_term0 - alu_term1;
            2'd2: expected = alu_term0 & alu_term1;
            2'd3: expected = alu_term0 | alu_term1;
            default: expected = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                                          err <= 1'b0;
        else if ((state == EXEC) && (alu_result != expected)) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a behavioural arithmetic unit closes the loop and
// each scenario task compares outputs against hand-computed values.
module tb_alu_sequencer;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_acc;
    logic [WIDTH-1:0] alu_term0;
    logic [WIDTH-1:0] alu_term1;
    logic [1:0]       alu_sel;
    logic [WIDTH-1:0] alu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic             err;

    logic             corrupt;
    logic [WIDTH-1:0] unit_out;
    int               errors = 0;
    int               checks = 0;

`ifdef ALU_SEQ_CHECK_EN
    localparam logic CHECK_BUILT = 1'b1;
`else
    localparam logic CHECK_BUILT = 1'b0;
`endif

    always #5 clk = ~clk;

    // Stand-in for the external arithmetic unit; corrupt flips bit 0 of its result.
    always_comb begin
        unit_out = '0;
        case (alu_sel)
            2'd0: unit_out = alu_term0 + alu_term1;
            2'd1: unit_out = alu_term0 - alu_term1;
            2'd2: unit_out = alu_term0 & alu_term1;
            default: unit_out = alu_term0 | alu_term1;
        endcase
    end
    assign alu_result = unit_out ^ {{(WIDTH-1){1'b0}}, corrupt};

    alu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_acc    (cmd_acc),
        .alu_term0  (alu_term0),
        .alu_term1  (alu_term1),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_zero   (rsp_zero),
        .err        (err)
    );

    // Present a command at a negedge and return at the negedge right after it is accepted.
    task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic use_acc, output logic ok);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_acc   = use_acc;
        ok        = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (cmd_ready) ok = 1'b1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    // Count negedges until rsp_valid, capture the response, then step past the handshake.
    task automatic get_rsp(output logic [WIDTH-1:0] data, output logic zero, output int lat,
                           output logic ok);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        ok   = rsp_valid;
        data = rsp_data;
        zero = rsp_zero;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got=%0b want=0", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%0b want=0", rsp_valid); end
        checks++; if ({alu_term0, alu_term1, alu_sel} !== '0) begin errors++; $display("FAIL reset_alu_regs got=%h/%h/%0d want=0", alu_term0, alu_term1, alu_sel); end
        checks++; if ({rsp_data, rsp_zero, err} !== '0) begin errors++; $display("FAIL reset_rsp got=%h z=%0b err=%0b want=0", rsp_data, rsp_zero, err); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_cmd_ready got=%0b want=1", cmd_ready); end
    endtask

    task automatic test_add();
        logic ok; logic [WIDTH-1:0] d; logic z; int lat;
        rsp_ready = 1'b1;
        send(2'd0, 32'd5, 32'd3, 1'b0, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL add_accept got=%0b want=1", ok); end
        checks++; if ({alu_sel, alu_term0, alu_term1} !== {2'd0, 32'd5, 32'd3}) begin errors++; $display("FAIL add_operands got=%0d/%0d/%0d want=0/5/3", alu_sel, alu_term0, alu_term1); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL add_busy got=%0b want=0", cmd_ready); end
        get_rsp(d, z, lat, ok);
        checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got=%0d want=1", lat); end
        checks++; if (d !== 32'd8 || z !== 1'b0) begin errors++; $display("FAIL add_data got=%h z=%0b want=8 z=0", d, z); end
        checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL add_return got=rdy%0b vld%0b want=rdy1 vld0", cmd_ready, rsp_valid); end
    endtask

    task automatic test_sub_and();
        logic ok; logic [WIDTH-1:0] d; logic z; int lat;
        send(2'd1, 32'd3, 32'd5, 1'b0, ok);
        get_rsp(d, z, lat, ok);
        checks++; if (d !== 32'hFFFF_FFFE || z !== 1'b0) begin errors++; $display("FAIL sub_wrap got=%h z=%0b want=fffffffe z=0", d, z); end
        send(2'd2, 32'hF0, 32'h0F, 1'b0, ok);
        get_rsp(d, z, lat, ok);
        checks++; if (d !== 32'd0 || z !== 1'b1) begin errors++; $display("FAIL and_zero got=%h z=%0b want=0 z=1", d, z); end
    endtask

    task automatic test_acc_chain();
        logic ok; logic [WIDTH-1:0] d; logic z; int lat;
        send(2'd0, 32'h10, 32'h0, 1'b0, ok);
        get_rsp(d, z, lat, ok);
        checks++; if (d !== 32'h10) begin errors++; $display("FAIL chain_seed got=%h want=10", d); end
        send(2'd0, 32'hDEAD, 32'h1, 1'b1, ok);
        checks++; if (alu_term0 !== 32'h10) begin errors++; $display("FAIL chain_term0 got=%h want=10", alu_term0); end
        get_rsp(d, z, lat, ok);
        checks++; if (d !== 32'h11) begin errors++; $display("FAIL chain_add got=%h want=11", d); end
        send(2'd3, 32'h5555, 32'h100, 1'b1, ok);
        get_rsp(d, z, lat, ok);
        checks++; if (d !== 32'h111) begin errors++; $display("FAIL chain_or got=%h want=111", d); end
    endtask

    task automatic test_back_to_back();
        logic ok; logic [WIDTH-1:0] d; logic z; int lat;
        rsp_ready = 1'b0;
        send(2'd0, 32'd1, 32'd2, 1'b0, ok);
        @(negedge clk);
        // Second command stays presented while the first response is stalled.
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 32'd100; cmd_b = 32'd1; cmd_acc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== 32'd3 || alu_term0 !== 32'd1) begin
                errors++;
                $display("FAIL stall_%0d got=rdy%0b vld%0b data=%h t0=%h want=rdy0 vld1 data=3 t0=1", i, cmd_ready, rsp_valid, rsp_data, alu_term0);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL release got=vld%0b rdy%0b want=vld0 rdy1", rsp_valid, cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (alu_term0 !== 32'd100 || cmd_ready !== 1'b0) begin errors++; $display("FAIL next_accept got=t0 %h rdy%0b want=t0 64 rdy0", alu_term0, cmd_ready); end
        get_rsp(d, z, lat, ok);
        checks++; if (ok !== 1'b1 || lat !== 1 || d !== 32'd101) begin errors++; $display("FAIL next_rsp got=ok%0b lat%0d %h want=ok1 lat1 65", ok, lat, d); end
    endtask

    task automatic test_reset_mid_op();
        logic ok; logic [WIDTH-1:0] d; logic z; int lat;
        send(2'd0, 32'd7, 32'd1, 1'b0, ok);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || alu_term0 !== '0) begin errors++; $display("FAIL abort got=rdy%0b vld%0b t0=%h want=rdy0 vld0 t0=0", cmd_ready, rsp_valid, alu_term0); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL no_rsp_%0d got=%0b want=0", i, rsp_valid); end
        end
        send(2'd0, 32'hFFFF, 32'd2, 1'b1, ok);
        get_rsp(d, z, lat, ok);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL acc_cleared got=%h want=2", d); end
    endtask

    task automatic test_checker();
        logic ok; logic [WIDTH-1:0] d; logic z; int lat;
        corrupt = 1'b1;
        send(2'd0, 32'd4, 32'd4, 1'b0, ok);
        get_rsp(d, z, lat, ok);
        corrupt = 1'b0;
        checks++; if (d !== 32'd9) begin errors++; $display("FAIL forced_rsp got=%h want=9", d); end
        checks++; if (err !== CHECK_BUILT) begin errors++; $display("FAIL err_set got=%0b want=%0b", err, CHECK_BUILT); end
        send(2'd0, 32'd1, 32'd1, 1'b0, ok);
        get_rsp(d, z, lat, ok);
        checks++; if (d !== 32'd2 || err !== CHECK_BUILT) begin errors++; $display("FAIL err_sticky got=%h err=%0b want=2 err=%0b", d, err, CHECK_BUILT); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got=%0b want=0", err); end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        cmd_acc = 1'b0; rsp_ready = 1'b0; corrupt = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_sub_and();
        test_acc_chain();
        test_back_to_back();
        test_reset_mid_op();
        test_checker();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
